// File: rtl/exp3_gravador_sequencia.sv
// ----------------------------------------------------------------------------
// exp3_gravador_sequencia
// Records a player-entered sequence of one-hot switch moves into the game's
// sequence memory. Each confirmed move is written to the next address, starting
// at 0, until the memory is full or the player ends the recording. The recorded
// length is also reported so that the playback side can use it as its limit.
//
// Ports
//   clock           : single clock, rising edge
//   reset           : asynchronous, active-low reset
//   iniciar         : level, starts a recording from the idle state
//   chaves          : player switches, sampled on an accepted confirm
//   confirmar       : confirm button (level), only its rising edge counts
//   terminar        : level, ends the recording while waiting for a move
//   mem_we          : sequence memory write enable (high only in grava)
//   mem_addr        : write address (position counter)
//   mem_data        : registered switch value being written
//   gravando        : high in every state except inicial and fim
//   jogada_invalida : one-cycle Mealy pulse on a rejected confirm
//   pronto          : high for the single cycle spent in fim
//   tamanho         : positions written in the last/current recording
//   db_estado       : debug state code
// ----------------------------------------------------------------------------
module exp3_gravador_sequencia #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 4,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [DATA_W-1:0] chaves,
    input  logic              confirmar,
    input  logic              terminar,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              gravando,
    output logic              jogada_invalida,
    output logic              pronto,
    output logic [ADDR_W:0]   tamanho,
    output logic [3:0]        db_estado
);

    localparam int unsigned TAM_W = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        PREPARACAO = 4'h1,
        ESPERA     = 4'h2,
        GRAVA      = 4'h4,
        PROXIMO    = 4'h6,
        FIM        = 4'hF
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] cont_q, cont_d;
    logic [TAM_W-1:0]  tam_q, tam_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic              confirmar_d_q;
    logic              mem_we_q, mem_we_d;
    logic              pronto_q, pronto_d;
    logic              gravando_q, gravando_d;
    logic              borda;
    logic              chaves_onehot;
    logic              invalida;

    // Rising edge of the confirm button; a held button produces one edge only.
    assign borda = confirmar & ~confirmar_d_q;

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign chaves_onehot = (chaves != '0) &&
                           ((chaves & (chaves - DATA_W'(1))) == '0);

    // Next-state, datapath and output look-ahead logic.
    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        tam_d      = tam_q;
        dado_d     = dado_q;
        invalida   = 1'b0;

        case (estado_q)
            INICIAL: begin
                if (iniciar) begin
                    estado_d = PREPARACAO;
                end
            end
            PREPARACAO: begin
                cont_d   = '0;
                tam_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                // terminar has priority over a simultaneous confirm
                if (terminar) begin
                    estado_d = FIM;
                end else if (borda) begin
                    if (chaves_onehot) begin
                        dado_d   = chaves;
                        estado_d = GRAVA;
                    end else begin
                        invalida = 1'b1;
                    end
                end
            end
            GRAVA: begin
                // Memory captures on this same edge, so the length follows it
                tam_d    = tam_q + TAM_W'(1);
                estado_d = PROXIMO;
            end
            PROXIMO: begin
                // Counter saturates at the last address; it never wraps
                if (cont_q == LAST_ADDR) begin
                    estado_d = FIM;
                end else begin
                    cont_d   = cont_q + ADDR_W'(1);
                    estado_d = ESPERA;
                end
            end
            FIM: begin
                estado_d = INICIAL;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase

        // Moore outputs are registered from the next state so they line up
        // with the state they belong to.
        mem_we_d   = (estado_d == GRAVA);
        pronto_d   = (estado_d == FIM);
        gravando_d = (estado_d != INICIAL) && (estado_d != FIM);
    end

    // All state, datapath and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q      <= INICIAL;
            cont_q        <= '0;
            tam_q         <= '0;
            dado_q        <= '0;
            confirmar_d_q <= 1'b0;
            mem_we_q      <= 1'b0;
            pronto_q      <= 1'b0;
            gravando_q    <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            cont_q        <= cont_d;
            tam_q         <= tam_d;
            dado_q        <= dado_d;
            confirmar_d_q <= confirmar;
            mem_we_q      <= mem_we_d;
            pronto_q      <= pronto_d;
            gravando_q    <= gravando_d;
        end
    end

    // Debug code decoded from the state register so that an illegal
    // encoding is visible as E before it recovers.
    always_comb begin
        db_estado = 4'hE;
        case (estado_q)
            INICIAL:    db_estado = 4'h0;
            PREPARACAO: db_estado = 4'h1;
            ESPERA:     db_estado = 4'h2;
            GRAVA:      db_estado = 4'h4;
            PROXIMO:    db_estado = 4'h6;
            FIM:        db_estado = 4'hF;
            default:    db_estado = 4'hE;
        endcase
    end

    assign mem_we          = mem_we_q;
    assign mem_addr        = cont_q;
    assign mem_data        = dado_q;
    assign gravando        = gravando_q;
    assign pronto          = pronto_q;
    assign tamanho         = tam_q;
    assign jogada_invalida = invalida;

endmodule
